// File: rtl/hls_checksum_pkg.sv
// ============================================================================
// Module   : hls_checksum_pkg
// Brief    : Shared state encoding and CRC-32 constants for the checksum responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hls_checksum_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FETCH = 2'd1;
    localparam state_t ST_BYTES = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    localparam logic [31:0] CRC32_POLY   = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;

endpackage

`default_nettype wire

// File: rtl/hls_checksum_responder_crc32_byte_step.sv
// ============================================================================
// Module   : crc32_byte_step
// Brief    : Folds one byte into a reflected CRC-32 state, purely combinational.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc32_byte_step
    import hls_checksum_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out
);

    logic [31:0] w_crc;

    always_comb begin
        w_crc = crc_in ^ {24'd0, data_in};
        for (int i = 0; i < 8; i++) begin
            w_crc = w_crc[0] ? ((w_crc >> 1) ^ CRC32_POLY) : (w_crc >> 1);
        end
        crc_out = w_crc;
    end

endmodule

`default_nettype wire

// File: rtl/hls_checksum_responder.sv
// ============================================================================
// Module   : hls_checksum_responder
// Brief    : HLS start/done responder folding a fed value stream into CRC-32.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hls_checksum_responder
    import hls_checksum_pkg::*;
#(
    parameter int VALUE_BYTES = 8,
    parameter int COUNT_W     = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start_port,
    input  logic [COUNT_W-1:0]       count_port,
    input  logic [8*VALUE_BYTES-1:0] val_data,
    input  logic                     val_valid,
    output logic                     val_ready,
    output logic                     done_port,
    output logic [31:0]              return_port
);

    localparam int IDX_W = (VALUE_BYTES > 1) ? $clog2(VALUE_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VALUE_BYTES - 1);

    state_t                   state_q, state_d;
    logic [COUNT_W-1:0]       remaining_q, remaining_d;
    logic [IDX_W-1:0]         byte_idx_q, byte_idx_d;
    logic [8*VALUE_BYTES-1:0] shreg_q, shreg_d;
    logic [31:0]              crc_q, crc_d;
    logic                     done_q, done_d;
    logic [31:0]              return_q, return_d;
    logic [31:0]              crc_step;

    crc32_byte_step u_step (
        .crc_in  (crc_q),
        .data_in (shreg_q[7:0]),
        .crc_out (crc_step)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        byte_idx_d  = byte_idx_q;
        shreg_d     = shreg_q;
        crc_d       = crc_q;
        return_d    = return_q;
        case (state_q)
            ST_IDLE: begin
                if (start_port) begin
                    remaining_d = count_port;
                    crc_d       = CRC32_INIT;
                    state_d     = (count_port == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (val_valid) begin
                    shreg_d     = val_data;
                    byte_idx_d  = '0;
                    remaining_d = remaining_q - COUNT_W'(1);
                    state_d     = ST_BYTES;
                end
            end
            ST_BYTES: begin
                crc_d      = crc_step;
                shreg_d    = shreg_q >> 8;
                byte_idx_d = byte_idx_q + IDX_W'(1);
                if (byte_idx_q == LAST_IDX) begin
                    state_d = (remaining_q != '0) ? ST_FETCH : ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Result is loaded on the edge entering DONE so it lines up with the pulse.
        done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
        if (done_d) begin
            return_d = crc_d ^ CRC32_XOROUT;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            byte_idx_q  <= '0;
            shreg_q     <= '0;
            crc_q       <= CRC32_INIT;
            done_q      <= 1'b0;
            return_q    <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            byte_idx_q  <= byte_idx_d;
            shreg_q     <= shreg_d;
            crc_q       <= crc_d;
            done_q      <= done_d;
            return_q    <= return_d;
        end
    end

    assign val_ready   = (state_q == ST_FETCH);
    assign done_port   = done_q;
    assign return_port = return_q;

endmodule

`default_nettype wire

// File: tb/tb_hls_checksum_responder.sv
// ============================================================================
// Module   : tb_hls_checksum_responder
// Brief    : Directed self-checking bench for the CRC-32 checksum responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hls_checksum_responder;

    logic        clock;
    logic        reset;
    logic        start_port;
    logic [15:0] count_port;
    logic [63:0] val_data;
    logic        val_valid;
    logic        val_ready;
    logic        done_port;
    logic [31:0] return_port;

    int n_checks;
    int n_pass;

    hls_checksum_responder #(
        .VALUE_BYTES (8),
        .COUNT_W     (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start_port  (start_port),
        .count_port  (count_port),
        .val_data    (val_data),
        .val_valid   (val_valid),
        .val_ready   (val_ready),
        .done_port   (done_port),
        .return_port (return_port)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Golden model: same value repeated n times, bytes LSB first.
    function automatic logic [31:0] crc_model(input logic [63:0] v, input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int k = 0; k < n; k++) begin
            for (int b = 0; b < 8; b++) begin
                c = c ^ {24'd0, v[8*b +: 8]};
                for (int j = 0; j < 8; j++) begin
                    if (c[0]) c = (c >> 1) ^ 32'hEDB88320;
                    else      c = c >> 1;
                end
            end
        end
        return c ^ 32'hFFFFFFFF;
    endfunction

    // Starts a run and watches it for a bounded number of cycles.
    task automatic run(input string nm, input logic [15:0] cnt, input logic [63:0] data,
                       input int stall_at, input int stall_len, input int spur1, input int spur2,
                       input int exp_cyc, input logic [31:0] exp_ret, input logic exp_ready_seen);
        int done_cyc;
        int n_done;
        logic ready_seen;
        done_cyc   = -1;
        n_done     = 0;
        ready_seen = 1'b0;
        start_port = 1'b1;
        count_port = cnt;
        val_data   = data;
        val_valid  = 1'b1;
        @(posedge clock);
        #1;
        start_port = 1'b0;
        count_port = 16'hDEAD;
        for (int cyc = 1; cyc <= exp_cyc + 5; cyc++) begin
            start_port = (cyc == spur1) || (cyc == spur2);
            val_valid  = !((cyc >= stall_at) && (cyc < stall_at + stall_len));
            if (val_ready) ready_seen = 1'b1;
            if (done_port) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            @(posedge clock);
            #1;
        end
        start_port = 1'b0;
        val_valid  = 1'b0;
        n_checks++;
        if (done_cyc !== exp_cyc)
            $display("FAIL %s done_cycle: got %0d expected %0d", nm, done_cyc, exp_cyc);
        else n_pass++;
        n_checks++;
        if (n_done !== 1)
            $display("FAIL %s done_pulses: got %0d expected 1", nm, n_done);
        else n_pass++;
        n_checks++;
        if (return_port !== exp_ret)
            $display("FAIL %s return_port: got %08h expected %08h", nm, return_port, exp_ret);
        else n_pass++;
        n_checks++;
        if (ready_seen !== exp_ready_seen)
            $display("FAIL %s val_ready_seen: got %0b expected %0b", nm, ready_seen, exp_ready_seen);
        else n_pass++;
    endtask

    task automatic check_idle_outputs(input string nm);
        n_checks++;
        if (done_port !== 1'b0) $display("FAIL %s done_port: got %0b expected 0", nm, done_port);
        else n_pass++;
        n_checks++;
        if (val_ready !== 1'b0) $display("FAIL %s val_ready: got %0b expected 0", nm, val_ready);
        else n_pass++;
        n_checks++;
        if (return_port !== 32'h0) $display("FAIL %s return_port: got %08h expected 00000000", nm, return_port);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        start_port = 1'b0;
        count_port = '0;
        val_data   = '0;
        val_valid  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_idle_outputs("reset");
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_single_zero();
        run("one_zero", 16'd1, 64'h0, 0, 0, -1, -1, 10, 32'h6522DF69, 1'b1);
    endtask

    task automatic test_ascii();
        run("ascii_12345678", 16'd1, 64'h3837363534333231, 0, 0, -1, -1, 10, 32'h9AE0DAAF, 1'b1);
    endtask

    task automatic test_count_zero();
        run("count_zero", 16'd0, 64'h0, 0, 0, -1, -1, 1, 32'h00000000, 1'b0);
    endtask

    task automatic test_stall();
        run("stall_two", 16'd2, 64'h0, 10, 3, -1, -1, 22, crc_model(64'h0, 2), 1'b1);
    endtask

    task automatic test_spurious_start();
        run("spurious", 16'd1, 64'h0, 0, 0, 5, 10, 10, 32'h6522DF69, 1'b1);
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if (return_port !== 32'h6522DF69 || done_port !== 1'b0)
            $display("FAIL spurious_after: got ret=%08h done=%0b expected ret=6522DF69 done=0",
                     return_port, done_port);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        start_port = 1'b1;
        count_port = 16'd1;
        val_data   = 64'h3837363534333231;
        val_valid  = 1'b1;
        @(posedge clock);
        #1;
        start_port = 1'b0;
        repeat (4) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check_idle_outputs("reset_mid");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        run("after_reset", 16'd1, 64'h0, 0, 0, -1, -1, 10, 32'h6522DF69, 1'b1);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_single_zero();
        test_ascii();
        test_count_zero();
        test_stall();
        test_spurious_start();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
